sequential_multiplicator_dispatcher: RTL and testbench
======================================================

// Module: sequential_multiplicator_dispatcher
// PURPOSE
//  Front/back end of sequential_multiplicator. Accepts operand pairs on a valid/ready request stream
//  and buffers them in a small FIFO. Issues one start pulse per pair and waits for done_out.
//  Captures product/overflow and presents them on a valid/ready response stream; one op in flight.
// PARAMETERS
//  WIDTH          8             operand width; product is 2*WIDTH (same value as the multiplier's package WIDTH)
//  DEPTH          4             request FIFO entries, power of two, >=2
//  TIMEOUT_CYCLES 4*WIDTH+8     watchdog limit in WAIT (used only with DISPATCH_TIMEOUT_EN)
// PORTS
//  clock                 in   1        system clock, all logic on posedge
//  reset_in              in   1        synchronous, active-high reset
//  req_valid_in          in   1        request valid
//  req_ready_out         out  1        request ready (= FIFO not full)
//  req_multiplicand_in   in   WIDTH    operand A
//  req_multiplier_in     in   WIDTH    operand B
//  mul_multiplicand_out  out  WIDTH    to multiplier multiplicand_in
//  mul_multiplier_out    out  WIDTH    to multiplier multiplier_in
//  mul_start_out         out  1        to multiplier start_in, 1-cycle pulse
//  mul_done_in           in   1        from multiplier done_out
//  mul_product_in        in   2*WIDTH  from multiplier product_out
//  mul_overflow_in       in   1        from multiplier overflow_out
//  rsp_valid_out         out  1        response valid
//  rsp_ready_in          in   1        response ready
//  rsp_product_out       out  2*WIDTH  captured product
//  rsp_overflow_out      out  1        captured overflow
//  rsp_timeout_out       out  1        watchdog fired (tied 0 without DISPATCH_TIMEOUT_EN)
//  fifo_count_out        out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - Reset (reset_in=1 at posedge): FIFO pointers/count=0, state=IDLE, every output register=0.
//    Resulting values: req_ready_out=1, all other outputs 0. Applies in any state; a done arriving after reset is ignored.
//  - FIFO: push on req_valid_in&&req_ready_out; pop only by FSM in IDLE.
//    Simultaneous push+pop leaves count unchanged; pointers wrap modulo DEPTH. No push when full.
//    No pop when empty.
//  - FSM IDLE: FIFO non-empty -> pop into operand regs, go START.
//  - FSM START: mul_start_out=1 for this single cycle -> WAIT.
//  - FSM WAIT: rising edge of mul_done_in (done=1, registered done_q=0) -> capture product/overflow.
//    Set rsp_valid_out=1, go HOLD.
//  - FSM HOLD: rsp_* stable while rsp_ready_in=0. On rsp_ready_in=1: rsp_valid_out=0 -> IDLE.
//  - Latency, empty FIFO, idle: accept at edge k; pop at k+1; mul_start_out high in cycle k+1..k+2.
//    rsp_valid_out rises at the edge after the done rising edge.
//  - mul_*_out operands are registered and held stable from START until the next pop.
//  - Done edges outside WAIT are ignored. Requests keep filling the FIFO during WAIT/HOLD.
// CONFIGURATION
//  DISPATCH_TIMEOUT_EN defined: cycle counter runs in WAIT, cleared on entry.
//    If it reaches TIMEOUT_CYCLES without a done edge: go HOLD with rsp_product_out=0, rsp_overflow_out=0, rsp_timeout_out=1.
//  DISPATCH_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; rsp_timeout_out constant 0.
// STRUCTURE
//  Shared package sequential_multiplicator_dispatch_pkg:
//    - operand_t/product_t typedefs
//    - dispatch_state_e {IDLE,START,WAIT,HOLD}
//    - req_t struct {multiplicand,multiplier}
//  Sub-module mult_req_fifo: synchronous FIFO of req_t, parameters DEPTH, ports push/pop/full/empty/count.
// TESTING (WIDTH=8, DEPTH=4, bench models multiplier with done N cycles after start)
//  1 Reset for 2 cycles -> req_ready_out=1, rsp_valid_out=0, mul_start_out=0, fifo_count_out=0.
//  2 Request 12*11, multiplier N=8 -> one start pulse with operands 12/11.
//    Response follows: product 132, overflow 0, timeout 0.
//  3 Multiplier stalled (no done), push 6 back-to-back -> 5 accepted (1 popped + 4 stored).
//    req_ready_out=0 on the 6th; fifo_count_out=4.
//  4 Two results pending, rsp_ready_in=0 for 10 cycles -> rsp_* stable, no second mul_start_out.
//    Releasing ready delivers both in order.
//  5 reset_in pulsed during WAIT with 3 queued -> next cycle IDLE, fifo_count_out=0, rsp_valid_out=0.
//    Later done ignored.
//  6 DISPATCH_TIMEOUT_EN defined, done never asserted -> TIMEOUT_CYCLES (40) after entering WAIT.
//    Response: product 0, timeout 1. Next request proceeds normally.

Source files
------------

// File: rtl/sequential_multiplicator_dispatch_pkg.sv
// sequential_multiplicator_dispatch_pkg: shared operand/product types, FSM states and request record
package sequential_multiplicator_dispatch_pkg;
  localparam int OP_WIDTH = 8;
  typedef logic [OP_WIDTH-1:0] operand_t;
  typedef logic [2*OP_WIDTH-1:0] product_t;
  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} dispatch_state_e;
  typedef struct packed {
    operand_t multiplicand;
    operand_t multiplier;
  } req_t;
endpackage

// File: rtl/sequential_multiplicator_dispatcher_fifo.sv
// mult_req_fifo: synchronous request FIFO of operand pairs with occupancy count
module mult_req_fifo
  import sequential_multiplicator_dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  req_t                     din,
  output req_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  req_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  // storage is written only on an accepted push, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap naturally at the power-of-two depth; push+pop keeps count
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/sequential_multiplicator_dispatcher.sv
// sequential_multiplicator_dispatcher: queues operand pairs, drives the multiplier one op at a time, returns results (DISPATCH_TIMEOUT_EN adds a WAIT watchdog)
module sequential_multiplicator_dispatcher
  import sequential_multiplicator_dispatch_pkg::*;
#(
  parameter int WIDTH = OP_WIDTH,
  parameter int DEPTH = 4
`ifdef DISPATCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4*WIDTH+8
`endif
) (
  input  logic                     clock,
  input  logic                     reset_in,
  input  logic                     req_valid_in,
  output logic                     req_ready_out,
  input  logic [WIDTH-1:0]         req_multiplicand_in,
  input  logic [WIDTH-1:0]         req_multiplier_in,
  output logic [WIDTH-1:0]         mul_multiplicand_out,
  output logic [WIDTH-1:0]         mul_multiplier_out,
  output logic                     mul_start_out,
  input  logic                     mul_done_in,
  input  logic [2*WIDTH-1:0]       mul_product_in,
  input  logic                     mul_overflow_in,
  output logic                     rsp_valid_out,
  input  logic                     rsp_ready_in,
  output logic [2*WIDTH-1:0]       rsp_product_out,
  output logic                     rsp_overflow_out,
  output logic                     rsp_timeout_out,
  output logic [$clog2(DEPTH):0]   fifo_count_out
);
  dispatch_state_e state, state_n;
  req_t head;
  logic full, empty, pop, done_q, done_edge, tmo, finish;
  mult_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clock),
    .rst  (reset_in),
    .push (req_valid_in),
    .pop  (pop),
    .din  ('{multiplicand: req_multiplicand_in, multiplier: req_multiplier_in}),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(fifo_count_out)
  );
  assign req_ready_out = !full;
  assign mul_start_out = state == START;
  // next-state: pop in IDLE, single START cycle, WAIT for done edge or watchdog, HOLD until consumed
  always_comb begin
    done_edge = mul_done_in && !done_q;
    pop = state == IDLE && !empty;
    finish = state == WAIT && (done_edge || tmo);
    state_n = state == IDLE  ? (empty ? IDLE : START) :
              state == START ? WAIT :
              state == WAIT  ? (finish ? HOLD : WAIT) :
                               (rsp_ready_in ? IDLE : HOLD);
  end
  // state register
  always_ff @(posedge clock)
    if (reset_in) state <= IDLE;
    else state <= state_n;
  // operand latch, done edge detector and response capture
  always_ff @(posedge clock)
    if (reset_in) begin
      done_q               <= 1'b0;
      mul_multiplicand_out <= '0;
      mul_multiplier_out   <= '0;
      rsp_valid_out        <= 1'b0;
      rsp_product_out      <= '0;
      rsp_overflow_out     <= 1'b0;
    end else begin
      done_q <= mul_done_in;
      if (pop) begin
        mul_multiplicand_out <= head.multiplicand;
        mul_multiplier_out   <= head.multiplier;
      end
      if (finish) begin
        rsp_valid_out    <= 1'b1;
        rsp_product_out  <= done_edge ? mul_product_in : '0;
        rsp_overflow_out <= done_edge && mul_overflow_in;
      end else if (state == HOLD && rsp_ready_in) rsp_valid_out <= 1'b0;
    end
`ifdef DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] wait_cnt;
  assign tmo = state == WAIT && wait_cnt == CW'(TIMEOUT_CYCLES-1);
  // watchdog counts WAIT cycles, cleared whenever outside WAIT
  always_ff @(posedge clock)
    if (reset_in || state != WAIT) wait_cnt <= '0;
    else wait_cnt <= wait_cnt + 1'b1;
  // timeout flag accompanies the response; a real done wins a same-cycle tie
  always_ff @(posedge clock)
    if (reset_in) rsp_timeout_out <= 1'b0;
    else if (finish) rsp_timeout_out <= !done_edge;
`else
  assign tmo = 1'b0;
  assign rsp_timeout_out = 1'b0;
`endif
endmodule

// File: tb/tb_sequential_multiplicator_dispatcher.sv
// tb_sequential_multiplicator_dispatcher: scoreboard bench with a behavioural multiplier (DISPATCH_TIMEOUT_EN enables the watchdog test)
module tb_sequential_multiplicator_dispatcher;
  logic clock = 0, reset_in = 1, req_valid_in = 0, rsp_ready_in = 1;
  logic [7:0] req_multiplicand_in = 0, req_multiplier_in = 0;
  logic req_ready_out, mul_start_out, rsp_valid_out, rsp_overflow_out, rsp_timeout_out;
  logic [7:0] mul_multiplicand_out, mul_multiplier_out;
  logic [15:0] rsp_product_out;
  logic [2:0] fifo_count_out;
  logic mul_done = 0, mul_ovf = 0, mul_stall = 0, m_busy = 0;
  logic [15:0] mul_product = 0;
  logic [7:0] m_a = 0, m_b = 0;
  int m_cnt = 0, mul_n = 8;
  int tests = 0, fails = 0, n_starts = 0, n_rsp = 0;
  typedef struct { logic [15:0] p; logic o; logic t; } rsp_s;
  rsp_s rq[$];
  logic [15:0] sq[$];
  logic [7:0]  va [10] = '{8'd12, 8'd255, 8'd200, 8'd0, 8'd1, 8'd128, 8'd100, 8'd17, 8'd250, 8'd181};
  logic [7:0]  vb [10] = '{8'd11, 8'd255, 8'd200, 8'd77, 8'd255, 8'd2, 8'd3, 8'd15, 8'd4, 8'd181};
  logic [15:0] vp [10] = '{16'd132, 16'd65025, 16'd40000, 16'd0, 16'd255, 16'd256, 16'd300, 16'd255, 16'd1000, 16'd32761};
  logic        vo [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  sequential_multiplicator_dispatcher dut (
    .clock(clock), .reset_in(reset_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_multiplicand_in(req_multiplicand_in), .req_multiplier_in(req_multiplier_in),
    .mul_multiplicand_out(mul_multiplicand_out), .mul_multiplier_out(mul_multiplier_out),
    .mul_start_out(mul_start_out), .mul_done_in(mul_done),
    .mul_product_in(mul_product), .mul_overflow_in(mul_ovf),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_product_out(rsp_product_out), .rsp_overflow_out(rsp_overflow_out),
    .rsp_timeout_out(rsp_timeout_out), .fifo_count_out(fifo_count_out)
  );

  always #5 clock = ~clock;

  function automatic logic [16:0] mm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] q;
    q = 16'(a) * 16'(b);
    return {q[15], q};
  endfunction

  always @(posedge clock) begin
    mul_done <= 1'b0;
    if (mul_start_out) begin
      m_busy <= 1'b1; m_cnt <= mul_n; m_a <= mul_multiplicand_out; m_b <= mul_multiplier_out;
    end else if (m_busy && !mul_stall) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0; mul_done <= 1'b1; {mul_ovf, mul_product} <= mm(m_a, m_b);
      end else m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clock) if (!reset_in) begin
    if (mul_start_out) begin
      n_starts++;
      if (sq.size() == 0) chk("start_unexpected", 1, 0);
      else chk("start_operands", {mul_multiplicand_out, mul_multiplier_out}, sq.pop_front());
    end
    if (rsp_valid_out && rsp_ready_in) begin
      n_rsp++;
      if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        rsp_s e;
        e = rq.pop_front();
        chk("rsp_product", rsp_product_out, e.p);
        chk("rsp_overflow", rsp_overflow_out, e.o);
        chk("rsp_timeout", rsp_timeout_out, e.t);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input logic o, input logic t, output bit acc);
    req_valid_in = 1; req_multiplicand_in = a; req_multiplier_in = b;
    @(negedge clock); acc = req_ready_out;
    @(posedge clock); #1; req_valid_in = 0;
    if (acc) begin
      sq.push_back({a, b});
      rq.push_back('{p, o, t});
    end
  endtask

  task automatic send_v(input int i, output bit acc);
    send(va[i], vb[i], vp[i], vo[i], 1'b0, acc);
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while ((sq.size() != 0 || rq.size() != 0 || rsp_valid_out) && c < maxc) begin
      @(posedge clock); #1; c++;
    end
    chk("drain_pending", sq.size() + rq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit acc;
    int c, s0, r0;
    logic stable;
    repeat (2) @(posedge clock);
    #1 reset_in = 0;
    chk("reset_req_ready", req_ready_out, 1);
    chk("reset_rsp_valid", rsp_valid_out, 0);
    chk("reset_start", mul_start_out, 0);
    chk("reset_count", fifo_count_out, 0);
    chk("reset_timeout", rsp_timeout_out, 0);

    mul_n = 8;
    send_v(0, acc);
    chk("t2_accept", acc, 1);
    @(negedge clock); chk("t2_start_not_yet", mul_start_out, 0);
    @(negedge clock); chk("t2_start_pulse", mul_start_out, 1);
    @(negedge clock); chk("t2_start_single", mul_start_out, 0);
    wait_idle(100);
    chk("t2_start_count", n_starts, 1);

    mul_stall = 1;
    for (int i = 1; i <= 6; i++) begin
      send_v(i, acc);
      chk($sformatf("t3_accept_%0d", i), acc, i < 6);
    end
    @(negedge clock);
    chk("t3_count_full", fifo_count_out, 4);
    chk("t3_ready_low", req_ready_out, 0);
    mul_stall = 0;
    wait_idle(400);

    rsp_ready_in = 0; mul_n = 3;
    send_v(7, acc);
    send_v(8, acc);
    c = 0;
    while (!rsp_valid_out && c < 50) begin @(negedge clock); c++; end
    chk("t4_rsp_arrived", rsp_valid_out, 1);
    s0 = n_starts; stable = 1;
    repeat (10) begin
      @(negedge clock);
      stable &= rsp_valid_out && rsp_product_out == 16'd255 && !rsp_overflow_out;
    end
    chk("t4_hold_stable", stable, 1);
    chk("t4_no_second_start", n_starts - s0, 0);
    chk("t4_second_queued", fifo_count_out, 1);
    @(posedge clock); #1 rsp_ready_in = 1;
    wait_idle(100);

    mul_stall = 1;
    for (int i = 0; i < 4; i++) send_v(i, acc);
    repeat (3) @(posedge clock);
    #1;
    chk("t5_queued", fifo_count_out, 3);
    reset_in = 1;
    @(posedge clock); #1 reset_in = 0;
    sq.delete(); rq.delete();
    chk("t5_count_cleared", fifo_count_out, 0);
    chk("t5_rsp_valid", rsp_valid_out, 0);
    chk("t5_req_ready", req_ready_out, 1);
    chk("t5_start", mul_start_out, 0);
    s0 = n_starts; r0 = n_rsp;
    mul_stall = 0;
    repeat (20) @(posedge clock);
    #1;
    chk("t5_late_done_no_rsp", n_rsp - r0, 0);
    chk("t5_late_done_no_start", n_starts - s0, 0);
    send_v(9, acc);
    wait_idle(100);

`ifdef DISPATCH_TIMEOUT_EN
    mul_stall = 1;
    send(8'd12, 8'd11, 16'd0, 1'b0, 1'b1, acc);
    c = 0;
    while (!mul_start_out && c < 10) begin @(negedge clock); c++; end
    chk("t6_start_seen", mul_start_out, 1);
    c = 0;
    do begin @(negedge clock); c++; end while (!rsp_valid_out && c < 100);
    chk("t6_timeout_latency", c, 41);
    wait_idle(20);
    mul_stall = 0;
    repeat (10) @(posedge clock);
    #1;
    send_v(0, acc);
    wait_idle(100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
